// File: rtl/crc_engine.sv
// Bit-serial MSB-first CRC engine: words arrive over valid/ready, one bit is
// folded per clock, and the checksum is offered over valid/ready after the last word.
module crc_engine #(
  parameter int              WIDTH = 8,
  parameter int              CRC_W = 16,
  parameter logic [CRC_W-1:0] POLY = 16'h1021,
  parameter logic [CRC_W-1:0] INIT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CRC_W-1:0] out_crc,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state;
  logic [CRC_W-1:0] crc;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] cnt;
  logic             last_q;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    fb = c[CRC_W-1] ^ b;
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      crc    <= INIT;
      sreg   <= '0;
      cnt    <= '0;
      last_q <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      crc   <= INIT;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sreg   <= in_data;
          last_q <= in_last;
          cnt    <= CNT_W'(WIDTH - 1);
          state  <= SHIFT;
        end
        SHIFT: begin
          crc  <= crc_step(crc, sreg[WIDTH-1]);
          sreg <= sreg << 1;
          cnt  <= cnt - 1'b1;
          // Non-last words return to IDLE with crc kept, so frames accumulate.
          if (cnt == '0) state <= last_q ? HOLD : IDLE;
        end
        HOLD: if (out_ready) begin
          crc   <= INIT;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs come from state only; clear masks them for its cycle.
  assign in_ready  = (state == IDLE) && !clear;
  assign out_valid = (state == HOLD) && !clear;
  assign busy      = (state != IDLE);
  assign out_crc   = crc;

endmodule

// File: tb/tb_crc_engine.sv
// Directed bench for crc_engine: CCITT-FALSE check string, INIT=0 instance,
// backpressure, clear, async reset and back-to-back streaming.
module tb_crc_engine;

  logic        clk, rst_n, clear, in_valid, in_last, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, busy;
  logic [15:0] out_crc;
  logic        in_ready1, out_valid1, busy1;
  logic [15:0] crc1;

  int cmp_cnt = 0;
  int fail_cnt = 0;
  int cyc = 0;

  crc_engine dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_crc(out_crc), .busy(busy)
  );

  // Same stimulus, INIT=0: handshake timing matches dut exactly.
  crc_engine #(.INIT(16'h0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
    .out_crc(crc1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Transfers one word; with full=1 also checks the
  // 8-cycle busy window and the outcome on the following cycle.
  task automatic send(input logic [7:0] d, input logic l, input logic full);
    int n;
    in_valid = 1'b1; in_data = d; in_last = l; n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("accept_timeout", 32'(n < 50), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (full) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        chk("rdy_low", 32'(in_ready), 0);
        chk("ov_low", 32'(out_valid), 0);
      end
      @(negedge clk);
      if (l) chk("ov_latency", 32'(out_valid), 1);
      else   chk("rdy_back", 32'(in_ready), 1);
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pop_ov", 32'(out_valid), 0);
    chk("pop_rdy", 32'(in_ready), 1);
  endtask

  task automatic send_msg();
    for (int i = 0; i < 9; i++) send(msg[i], i == 8, 1'b1);
  endtask

  initial begin
    int n, prev, acc, seen;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_crc", 32'(out_crc), 32'h0000FFFF);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_crc_init0", 32'(crc1), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // INIT=0 instance: 0x01 -> 0x1021, 0x00 -> 0x0000
    send(8'h01, 1'b1, 1'b1);
    chk("init0_x01", 32'(crc1), 32'h1021);
    pop();
    chk("init0_after_pop", 32'(crc1), 0);
    chk("after_pop_crc", 32'(out_crc), 32'hFFFF);
    send(8'h00, 1'b1, 1'b1);
    chk("init0_x00", 32'(crc1), 0);
    pop();

    // Check string and backpressure
    send_msg();
    chk("check_str", 32'(out_crc), 32'h29B1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ov", 32'(out_valid), 1);
      chk("bp_crc", 32'(out_crc), 32'h29B1);
      chk("bp_rdy", 32'(in_ready), 0);
    end
    pop();
    chk("bp_pop_crc", 32'(out_crc), 32'hFFFF);

    // Clear partway through word 0x35
    for (int i = 0; i < 4; i++) send(msg[i], 1'b0, 1'b1);
    send(8'h35, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    clear = 1'b1; #1;
    chk("clr_rdy_low", 32'(in_ready), 0);
    chk("clr_ov_low", 32'(out_valid), 0);
    @(negedge clk);
    clear = 1'b0; #1;
    chk("clr_rdy", 32'(in_ready), 1);
    chk("clr_crc", 32'(out_crc), 32'hFFFF);
    chk("clr_busy", 32'(busy), 0);
    @(negedge clk);
    send_msg();
    chk("clr_resend", 32'(out_crc), 32'h29B1);
    pop();

    // Async reset mid-SHIFT
    send(8'h31, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0; #1;
    chk("ars_shift_rdy", 32'(in_ready), 1);
    chk("ars_shift_ov", 32'(out_valid), 0);
    chk("ars_shift_crc", 32'(out_crc), 32'hFFFF);
    chk("ars_shift_busy", 32'(busy), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Async reset in HOLD
    send_msg();
    #2 rst_n = 1'b0; #1;
    chk("ars_hold_ov", 32'(out_valid), 0);
    chk("ars_hold_crc", 32'(out_crc), 32'hFFFF);
    chk("ars_hold_crc0", 32'(crc1), 0);
    chk("ars_hold_busy", 32'(busy), 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (12) begin @(negedge clk); if (out_valid) seen++; end
    chk("no_ov_after_rst", 32'(seen), 0);

    // Back-to-back with in_valid held high
    in_valid = 1'b1; prev = 0;
    for (int i = 0; i < 9; i++) begin
      in_data = msg[i]; in_last = (i == 8); n = 0;
      while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("b2b_timeout", 32'(n < 50), 1);
      acc = cyc + 1;
      if (i > 0) chk("b2b_gap", 32'(acc - prev), 9);
      prev = acc;
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; n = 0;
    while (out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("b2b_ov", 32'(out_valid), 1);
    chk("b2b_crc", 32'(out_crc), 32'h29B1);
    pop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/crc_engine.md
# crc_engine

Parametrised bit-serial CRC/XOR checksum engine, the sequential successor to the single-bit XOR gate in the gate library. It accepts data words over a valid/ready handshake and folds them MSB-first into a CRC register through XOR feedback, one bit per clock. When the word flagged last has been folded in, it presents the checksum over a valid/ready output. It sits between a word-stream producer (memory scanner, serial receiver) and any consumer needing frame integrity checks.

## Interface
- WIDTH, 8: data word width in bits, ≥1.
- CRC_W, 16: CRC register width in bits, ≥2.
- POLY, 16'h1021: generator polynomial, implicit x^CRC_W term omitted, CRC_W bits.
- INIT, 16'hFFFF: CRC register value at reset, after clear and after each result is consumed, CRC_W bits.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort/reinitialise, highest priority after reset.
- in_valid  in  1  in_data/in_last valid.
- in_ready  out  1  engine can accept a word.
- in_data  in  WIDTH  data word, MSB processed first.
- in_last  in  1  word is the final word of the frame.
- out_valid  out  1  out_crc holds a finished checksum.
- out_ready  in  1  consumer takes the checksum.
- out_crc  out  CRC_W  CRC register contents.
- busy  out  1  state is SHIFT or HOLD.

## Operation
- Per-bit update: fb = crc[CRC_W-1] ^ bit; crc <= {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0). No reflection, no final XOR.
- States: IDLE, SHIFT, HOLD.
- IDLE: in_ready = 1 (when clear low). A transfer occurs on an edge with in_valid && in_ready: latch in_data into a shift register, latch in_last, load bit counter with WIDTH-1, go to SHIFT.
- SHIFT: each cycle fold the current MSB of the shift register into crc, shift left, decrement counter. On the cycle the counter is 0: go to HOLD if latched last = 1, otherwise to IDLE with crc retained (accumulates across words).
- HOLD: out_valid = 1, out_crc stable. On out_ready: crc <= INIT, go to IDLE.
- out_crc always shows the live crc register; only meaningful while out_valid = 1.
- clear = 1: crc <= INIT, state <= IDLE, discards any word in progress or pending result; in_ready = 0 and out_valid = 0 during the clear cycle; no transfer occurs on that edge.
- rst_n low: immediately state IDLE, crc INIT, counter 0, shift register 0, latched last 0, regardless of clock.
- Counter width is ceil(log2(WIDTH)), minimum 1.

## Timing
- Reset values: in_ready 1, out_valid 0, out_crc INIT, busy 0.
- in_ready and out_valid are decoded from registered state only (no combinational path from in_valid/out_ready).
- Latency: word accepted at edge T; out_valid high from edge T+WIDTH for a last word.
- Throughput: one word per WIDTH+1 cycles (one IDLE cycle between words).
- HOLD with out_ready low: out_valid, out_crc held indefinitely; in_ready stays 0.
- HOLD to IDLE on the out_ready edge; a new word may be accepted on the next edge, not the same one.
- clear and reset during SHIFT or HOLD: no partial result is ever emitted.
- in_valid high outside IDLE: ignored, no data lost because in_ready = 0.

## Test plan
- WIDTH=8, defaults; after reset release, words 0x31..0x39 ("123456789"), in_last on 0x39 -> out_valid with out_crc = 0x29B1; in_ready low for exactly 8 cycles after each acceptance.
- INIT=0, single word 0x01 with in_last -> out_crc = 0x1021 exactly 8 cycles after acceptance; word 0x00 with INIT=0 -> out_crc = 0x0000.
- Backpressure: after result, hold out_ready low 5 cycles -> out_valid = 1, out_crc = 0x29B1 constant, in_ready = 0 throughout; then out_ready pulse -> IDLE, out_crc = 0xFFFF next cycle.
- Assert clear at 4th bit of word 0x35 -> in_ready 1 next cycle, out_crc = 0xFFFF; resending full "123456789" -> 0x29B1.
- Drop rst_n asynchronously mid-SHIFT and during HOLD -> outputs return to reset values without a clock edge; no out_valid pulse after release.
- Back-to-back in_valid held high for 9 words -> each accepted exactly 9 cycles apart, final result 0x29B1.
